// File: rtl/boot_copier_if.sv
// -----------------------------------------------------------------------------
// boot_copier_if
//   Bundles the boot copier's control/status handshake and both memory buses.
//   The master modport is the copy engine; the slave modport is the
//   surrounding board logic (start source, boot ROM, main RAM, reset
//   controller consuming cpu_hold).
//
//   start      engine <- env   pulse: begin a copy
//   busy       engine -> env   copy or verify in progress
//   done       engine -> env   sticky: engine finished (pass or fail)
//   error      engine -> env   sticky: verify mismatch
//   err_addr   engine -> env   word index of first mismatch
//   cpu_hold   engine -> env   hold CPU in reset
//   rom_addr   engine -> ROM   ROM address
//   rom_oe     engine -> ROM   ROM output enable
//   rom_data   ROM -> engine   ROM read data
//   ram_addr   engine -> RAM   RAM address
//   ram_we     engine -> RAM   RAM write strobe
//   ram_oe     engine -> RAM   RAM output enable
//   ram_wdata  engine -> RAM   RAM write data
//   ram_rdata  RAM -> engine   RAM read data (combinational)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface boot_copier_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_addr;
  logic          cpu_hold;
  logic [AW-1:0] rom_addr;
  logic          rom_oe;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_oe;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    input  start, rom_data, ram_rdata,
    output busy, done, error, err_addr, cpu_hold,
           rom_addr, rom_oe, ram_addr, ram_we, ram_oe, ram_wdata
  );

  modport slave (
    output start, rom_data, ram_rdata,
    input  busy, done, error, err_addr, cpu_hold,
           rom_addr, rom_oe, ram_addr, ram_we, ram_oe, ram_wdata
  );
endinterface

// File: rtl/boot_copier.sv
// -----------------------------------------------------------------------------
// boot_copier
//   Boot-time block-copy engine. Copies LEN words from a ROM window starting
//   at SRC_BASE into a RAM window starting at DST_BASE, then (VERIFY=1) reads
//   both back and compares them. The CPU is held in reset until a copy has
//   completed cleanly; a verify mismatch keeps it held and reports the word
//   index of the first bad word.
//
//   clk   in   clock
//   rst   in   reset, asynchronous, active-high
//   bus   master side of boot_copier_if (handshake, status, ROM and RAM buses)
//
//   Window addresses are AW-bit sums and wrap modulo 2**AW.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module boot_copier #(
  parameter int            AW         = 12,
  parameter int            DW         = 8,
  parameter int            LEN        = 4096,
  parameter logic [AW-1:0] SRC_BASE   = '0,
  parameter logic [AW-1:0] DST_BASE   = '0,
  parameter int            ROM_LAT    = 1,
  parameter int            VERIFY     = 1,
  parameter int            AUTO_START = 1
) (
  input logic           clk,
  input logic           rst,
  boot_copier_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_C_RD,
    S_C_WR,
    S_V_RD,
    S_V_CMP,
    S_DONE,
    S_ERR
  } state_e;

  // Latency counter runs 0..ROM_LAT-1 while an address is held on the ROM.
  localparam int            LW       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ROM_LAT - 1);
  localparam logic [AW:0]   LAST_IDX = (AW + 1)'(LEN - 1);

  if (LEN < 1 || LEN > (1 << AW)) begin : g_bad_len
    $error("boot_copier: LEN must be in 1..2**AW");
  end
  if (ROM_LAT < 1) begin : g_bad_lat
    $error("boot_copier: ROM_LAT must be >= 1");
  end

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [DW-1:0] wreg_q, wreg_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          auto_q, auto_d;

  logic [AW-1:0] idx_lo;
  logic          rom_oe, ram_we, ram_oe;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [DW-1:0] ram_wdata;

  assign idx_lo = idx_q[AW-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wreg_q     <= '0;
      lat_q      <= '0;
      err_addr_q <= '0;
      // Re-armed by every reset so that the first edge after release starts
      // a copy without an explicit start pulse.
      auto_q     <= (AUTO_START != 0);
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wreg_q     <= wreg_d;
      lat_q      <= lat_d;
      err_addr_q <= err_addr_d;
      auto_q     <= auto_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wreg_d     = wreg_q;
    lat_d      = lat_q;
    err_addr_d = err_addr_q;
    auto_d     = 1'b0;
    rom_oe     = 1'b0;
    rom_addr   = '0;
    ram_we     = 1'b0;
    ram_oe     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start || auto_q) begin
          idx_d   = '0;
          lat_d   = '0;
          state_d = S_C_RD;
        end
      end

      // Copy and verify reads are identical on the ROM side; only the
      // follow-on state differs.
      S_C_RD, S_V_RD: begin
        rom_oe   = 1'b1;
        rom_addr = SRC_BASE + idx_lo;
        if (lat_q == LAT_LAST) begin
          wreg_d  = bus.rom_data;
          lat_d   = '0;
          state_d = (state_q == S_C_RD) ? S_C_WR : S_V_CMP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_C_WR: begin
        ram_we    = 1'b1;
        ram_addr  = DST_BASE + idx_lo;
        ram_wdata = wreg_q;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = (VERIFY != 0) ? S_V_RD : S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_C_RD;
        end
      end

      S_V_CMP: begin
        ram_oe   = 1'b1;
        ram_addr = DST_BASE + idx_lo;
        if (bus.ram_rdata != wreg_q) begin
          err_addr_d = idx_lo;
          state_d    = S_ERR;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_V_RD;
        end
      end

      // Terminal states: a start pulse reruns the whole copy from word 0.
      S_DONE, S_ERR: begin
        if (bus.start) begin
          idx_d      = '0;
          lat_d      = '0;
          err_addr_d = '0;
          state_d    = S_C_RD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status is decoded straight from the state register so that an
  // asynchronous reset clears it in the same cycle.
  assign bus.busy      = (state_q == S_C_RD) || (state_q == S_C_WR) ||
                         (state_q == S_V_RD) || (state_q == S_V_CMP);
  assign bus.done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.error     = (state_q == S_ERR);
  assign bus.err_addr  = err_addr_q;
  assign bus.cpu_hold  = (state_q != S_DONE);
  assign bus.rom_addr  = rom_addr;
  assign bus.rom_oe    = rom_oe;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_we    = ram_we;
  assign bus.ram_oe    = ram_oe;
  assign bus.ram_wdata = ram_wdata;

endmodule

// File: tb/tb_boot_copier.sv
// -----------------------------------------------------------------------------
// tb_boot_copier
//   Four copier instances, each with its own reset, ROM model and RAM model:
//     0: LEN=16, ROM_LAT=1, VERIFY=1, AUTO_START=1   (main instance)
//     1: same, VERIFY=0
//     2: LEN=4, SRC_BASE=14, DST_BASE=12, ROM_LAT=3  (wrapping windows)
//     3: same as 0, AUTO_START=0
//   ROM[a] = a ^ 8'hA5. The ROM model returns inverted data until the address
//   has been held for ROM_LAT cycles. Expected ROM reads and RAM writes are
//   queued when a run is launched and popped as the engine produces them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_boot_copier;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NI    = 4;
  localparam int DEPTH = 16;

  function automatic int cfg_len(input int g);
    return (g == 2) ? 4 : 16;
  endfunction
  function automatic int cfg_src(input int g);
    return (g == 2) ? 14 : 0;
  endfunction
  function automatic int cfg_dst(input int g);
    return (g == 2) ? 12 : 0;
  endfunction
  function automatic int cfg_lat(input int g);
    return (g == 2) ? 3 : 1;
  endfunction
  function automatic int cfg_verify(input int g);
    return (g == 1) ? 0 : 1;
  endfunction
  function automatic int cfg_auto(input int g);
    return (g == 3) ? 0 : 1;
  endfunction
  function automatic logic [DW-1:0] rom_word(input int a);
    return DW'(a % DEPTH) ^ 8'hA5;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v   = '1;
  logic [NI-1:0] start_v = '0;
  logic          corrupt = 1'b0;

  logic [NI-1:0] busy_v, done_v, error_v, hold_v, rom_oe_v, ram_we_v, ram_oe_v;
  logic [AW-1:0] rom_addr_v [NI];
  logic [AW-1:0] ram_addr_v [NI];
  logic [AW-1:0] err_addr_v [NI];
  logic [DW-1:0] wdata_v    [NI];
  logic [DW-1:0] ram_m      [NI][DEPTH];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    boot_copier_if #(.AW(AW), .DW(DW)) bus ();

    boot_copier #(
      .AW        (AW),
      .DW        (DW),
      .LEN       (cfg_len(g)),
      .SRC_BASE  (AW'(cfg_src(g))),
      .DST_BASE  (AW'(cfg_dst(g))),
      .ROM_LAT   (cfg_lat(g)),
      .VERIFY    (cfg_verify(g)),
      .AUTO_START(cfg_auto(g))
    ) u_dut (
      .clk(clk),
      .rst(rst_v[g]),
      .bus(bus)
    );

    int rd_cnt = 0;
    always @(posedge clk) rd_cnt <= bus.rom_oe ? rd_cnt + 1 : 0;

    assign bus.start    = start_v[g];
    assign bus.rom_data = (bus.rom_oe && rd_cnt >= cfg_lat(g) - 1) ?
                          rom_word(int'(bus.rom_addr)) : ~rom_word(int'(bus.rom_addr));

    always @(posedge clk) if (bus.ram_we) ram_m[g][bus.ram_addr] <= bus.ram_wdata;
    assign bus.ram_rdata = ram_m[g][bus.ram_addr] ^
                           ((corrupt && g == 0 && bus.ram_addr == AW'(5)) ? 8'h5A : 8'h00);

    assign busy_v[g]     = bus.busy;
    assign done_v[g]     = bus.done;
    assign error_v[g]    = bus.error;
    assign hold_v[g]     = bus.cpu_hold;
    assign rom_oe_v[g]   = bus.rom_oe;
    assign ram_we_v[g]   = bus.ram_we;
    assign ram_oe_v[g]   = bus.ram_oe;
    assign rom_addr_v[g] = bus.rom_addr;
    assign ram_addr_v[g] = bus.ram_addr;
    assign err_addr_v[g] = bus.err_addr;
    assign wdata_v[g]    = bus.ram_wdata;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr [$];
  logic [AW-1:0] exp_rd [$];
  int checks = 0;
  int errors = 0;

  // Queue the full expected ROM-read and RAM-write sequence of one run.
  task automatic push_run(input int g);
    exp_wr.delete();
    exp_rd.delete();
    for (int w = 0; w < cfg_len(g); w++) begin
      for (int k = 0; k < cfg_lat(g); k++) exp_rd.push_back(AW'((cfg_src(g) + w) % DEPTH));
      exp_wr.push_back({AW'((cfg_dst(g) + w) % DEPTH), rom_word(cfg_src(g) + w)});
    end
    if (cfg_verify(g) != 0)
      for (int w = 0; w < cfg_len(g); w++)
        for (int k = 0; k < cfg_lat(g); k++) exp_rd.push_back(AW'((cfg_src(g) + w) % DEPTH));
  endtask

  // Steps instance g edge by edge (edge 1 = start-sampling edge), pops the
  // scoreboard on every strobe and returns the edge at which done was seen
  // (-1 if the budget ran out). A nonzero pulse_at re-pulses start so that
  // edge pulse_at samples it.
  task automatic watch(input int g, input int budget, input int pulse_at,
                       output int done_edge, output int oe_cycles);
    wr_t           w;
    logic [AW-1:0] a;
    done_edge = -1;
    oe_cycles = 0;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk);
      #1;
      if (start_v[g]) start_v[g] = 1'b0;
      if (pulse_at != 0 && e + 1 == pulse_at) start_v[g] = 1'b1;
      checks++;
      if (int'(rom_oe_v[g]) + int'(ram_we_v[g]) + int'(ram_oe_v[g]) > 1) begin
        errors++;
        $display("FAIL strobe_overlap inst%0d edge %0d: rom_oe/ram_we/ram_oe=%b%b%b, want at most one",
                 g, e, rom_oe_v[g], ram_we_v[g], ram_oe_v[g]);
      end
      if (ram_we_v[g]) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write inst%0d edge %0d: addr=%0d data=%h", g, e,
                   ram_addr_v[g], wdata_v[g]);
        end else begin
          w = exp_wr.pop_front();
          if ({ram_addr_v[g], wdata_v[g]} !== w) begin
            errors++;
            $display("FAIL ram_write inst%0d edge %0d: got addr=%0d data=%h, want addr=%0d data=%h",
                     g, e, ram_addr_v[g], wdata_v[g], w.addr, w.data);
          end
        end
      end
      if (rom_oe_v[g]) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rom_read inst%0d edge %0d: addr=%0d", g, e, rom_addr_v[g]);
        end else begin
          a = exp_rd.pop_front();
          if (rom_addr_v[g] !== a) begin
            errors++;
            $display("FAIL rom_addr inst%0d edge %0d: got %0d, want %0d", g, e, rom_addr_v[g], a);
          end
        end
      end
      if (ram_oe_v[g]) oe_cycles++;
      if (done_v[g]) begin
        done_edge = e;
        break;
      end
    end
  endtask

  // Common end-of-run checks: done edge, status flags, scoreboard drained.
  task automatic check_end(input string name, input int g, input int de, input int want_de,
                           input logic want_err, input logic want_hold);
    checks++;
    if (de !== want_de) begin
      errors++;
      $display("FAIL %s_done_edge: got %0d, want %0d", name, de, want_de);
    end
    checks++;
    if ({busy_v[g], done_v[g], error_v[g], hold_v[g]} !== {1'b0, 1'b1, want_err, want_hold}) begin
      errors++;
      $display("FAIL %s_status: busy/done/error/hold got %b%b%b%b, want 01%b%b",
               name, busy_v[g], done_v[g], error_v[g], hold_v[g], want_err, want_hold);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_writes_left: %0d expected writes never seen", name, exp_wr.size());
    end
  endtask

  task automatic check_ram(input string name, input int g);
    for (int w = 0; w < cfg_len(g); w++) begin
      checks++;
      if (ram_m[g][(cfg_dst(g) + w) % DEPTH] !== rom_word(cfg_src(g) + w)) begin
        errors++;
        $display("FAIL %s_ram[%0d]: got %h, want %h", name, (cfg_dst(g) + w) % DEPTH,
                 ram_m[g][(cfg_dst(g) + w) % DEPTH], rom_word(cfg_src(g) + w));
      end
    end
  endtask

  task automatic check_idle_outputs(input string name, input int g);
    checks++;
    if ({busy_v[g], done_v[g], error_v[g], hold_v[g], rom_oe_v[g], ram_we_v[g], ram_oe_v[g]} !== 7'b0001000 ||
        rom_addr_v[g] !== '0 || ram_addr_v[g] !== '0 || err_addr_v[g] !== '0 || wdata_v[g] !== '0) begin
      errors++;
      $display("FAIL %s inst%0d: flags=%b%b%b%b%b%b%b addr=%0d/%0d/%0d wdata=%h, want 0001000 and zeros",
               name, g, busy_v[g], done_v[g], error_v[g], hold_v[g], rom_oe_v[g], ram_we_v[g],
               ram_oe_v[g], rom_addr_v[g], ram_addr_v[g], err_addr_v[g], wdata_v[g]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) check_idle_outputs("reset_state", g);
  endtask

  task automatic test_copy_verify();
    int de, oe;
    push_run(0);
    @(negedge clk);
    rst_v[0] = 1'b0;
    watch(0, 200, 0, de, oe);
    check_end("copy_verify", 0, de, 65, 1'b0, 1'b0);
    check_ram("copy_verify", 0);
    checks++;
    if (oe !== 16) begin
      errors++;
      $display("FAIL copy_verify_ram_oe_cycles: got %0d, want 16", oe);
    end
  endtask

  task automatic test_no_verify();
    int de, oe;
    push_run(1);
    @(negedge clk);
    rst_v[1] = 1'b0;
    watch(1, 200, 0, de, oe);
    check_end("no_verify", 1, de, 33, 1'b0, 1'b0);
    check_ram("no_verify", 1);
    checks++;
    if (oe !== 0) begin
      errors++;
      $display("FAIL no_verify_ram_oe_cycles: got %0d, want 0", oe);
    end
  endtask

  task automatic test_wrap();
    int de, oe;
    push_run(2);
    @(negedge clk);
    rst_v[2] = 1'b0;
    watch(2, 200, 0, de, oe);
    check_end("wrap", 2, de, 33, 1'b0, 1'b0);
    check_ram("wrap", 2);
    checks++;
    if (exp_rd.size() != 0) begin
      errors++;
      $display("FAIL wrap_rom_reads_left: %0d expected ROM cycles never seen", exp_rd.size());
    end
  endtask

  task automatic test_verify_error();
    int de, oe;
    corrupt = 1'b1;
    push_run(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    watch(0, 200, 0, de, oe);
    check_end("verify_error", 0, de, 45, 1'b1, 1'b1);
    checks++;
    if (err_addr_v[0] !== AW'(5)) begin
      errors++;
      $display("FAIL verify_error_err_addr: got %0d, want 5", err_addr_v[0]);
    end
    corrupt = 1'b0;
    push_run(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    watch(0, 200, 0, de, oe);
    check_end("rerun", 0, de, 65, 1'b0, 1'b0);
    checks++;
    if (err_addr_v[0] !== '0) begin
      errors++;
      $display("FAIL rerun_err_addr: got %0d, want 0", err_addr_v[0]);
    end
  endtask

  task automatic test_reset_mid();
    int de, oe;
    push_run(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    // Edge 15 enters the ROM read of word 7; stop just after it.
    watch(0, 15, 0, de, oe);
    checks++;
    if (de !== -1 || busy_v[0] !== 1'b1 || rom_oe_v[0] !== 1'b1 || rom_addr_v[0] !== AW'(7)) begin
      errors++;
      $display("FAIL reset_mid_pre: done_edge=%0d busy=%b rom_oe=%b rom_addr=%0d, want -1 1 1 7",
               de, busy_v[0], rom_oe_v[0], rom_addr_v[0]);
    end
    rst_v[0] = 1'b1;
    #1;
    check_idle_outputs("reset_mid_async", 0);
    @(negedge clk);
    push_run(0);
    @(negedge clk);
    rst_v[0] = 1'b0;
    watch(0, 200, 0, de, oe);
    check_end("reset_mid_rerun", 0, de, 65, 1'b0, 1'b0);
    check_ram("reset_mid_rerun", 0);
  endtask

  task automatic test_back_to_back();
    int de, oe;
    push_run(0);
    @(negedge clk);
    start_v[0] = 1'b1;
    watch(0, 200, 20, de, oe);
    check_end("start_while_busy", 0, de, 65, 1'b0, 1'b0);
  endtask

  task automatic test_manual_start();
    int de, oe;
    @(negedge clk);
    rst_v[3] = 1'b0;
    repeat (10) @(negedge clk);
    check_idle_outputs("manual_idle", 3);
    push_run(3);
    start_v[3] = 1'b1;
    watch(3, 200, 0, de, oe);
    check_end("manual_start", 3, de, 65, 1'b0, 1'b0);
    check_ram("manual_start", 3);
  endtask

  initial begin
    test_reset();
    test_copy_verify();
    test_no_verify();
    test_wrap();
    test_verify_error();
    test_reset_mid();
    test_back_to_back();
    test_manual_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
